pb_eoc_reporter: RTL

Chip-side end-of-computation (EOC) reporter for the picobello SoC. It is the responder to the simulation VIP's EOC polling and UART monitoring. Software on any core writes a completion word to a memory-mapped register. The block latches the exit code, raises a sticky `eoc_o` flag, and (optionally) serialises a 5-byte EOC frame on a dedicated UART TX line that the bench or external hardware can decode. It sits on the peripheral register bus next to the Cheshire scratch registers.

---
 rtl/pb_eoc_reporter.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/pb_eoc_reporter.sv
// -----------------------------------------------------------------------------
// pb_eoc_reporter
//
// End-of-computation reporter. Software writes a completion word to the EOC
// register; the first write with bit 0 set latches the exit code, raises a
// sticky eoc_o flag and (optionally) sends a 5-byte 8N1 frame on uart_tx_o:
// SyncByte followed by exit_code_o bytes, least significant byte first.
//
// Configuration macro: PB_EOC_UART_EN
//   defined   : UART TX state machine compiled in.
//   undefined : no TX logic, uart_tx_o tied high, STATUS.tx_busy reads 0.
//
// Parameters:
//   ClkDiv   - clock cycles per UART bit (>= 2)
//   SyncByte - first byte of every frame
//
// Ports:
//   clk_i        in   clock
//   rst_ni       in   asynchronous active-low reset
//   req_i        in   register request valid
//   we_i         in   1 = write, 0 = read
//   addr_i[3:0]  in   byte address, [3:2] selects the word
//   wdata_i[31:0]in   write data
//   gnt_o        out  grant (equal to req_i)
//   rvalid_o     out  response valid, one cycle after each grant
//   rdata_o[31:0]out  read data, 0 when no read response
//   eoc_o        out  sticky end-of-computation flag
//   exit_code_o  out  latched exit code (bit 31 always 0)
//   uart_tx_o    out  8N1 serial line, idle high
//
// Register map: 0x0 EOC (W), 0x4 STATUS (R), 0x8 EXIT (R), 0xC reserved.
// -----------------------------------------------------------------------------
module pb_eoc_reporter #(
    parameter int         ClkDiv   = 16,
    parameter logic [7:0] SyncByte = 8'hE0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [3:0]  addr_i,
    input  logic [31:0] wdata_i,
    output logic        gnt_o,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        eoc_o,
    output logic [31:0] exit_code_o,
    output logic        uart_tx_o
);

    logic        eoc_q, eoc_d;
    logic [31:0] exit_q, exit_d;
    logic        rvalid_q;
    logic [31:0] rdata_q, rdata_d;
    logic        tx_busy;
    logic        eoc_set;

    // Byte offset within a word carries no meaning for this block.
    logic unused_addr_bits;
    assign unused_addr_bits = ^addr_i[1:0];

    assign gnt_o = req_i;

    // Only the first qualifying EOC write wins; later ones are dropped.
    assign eoc_set = req_i & we_i & (addr_i[3:2] == 2'd0) & wdata_i[0] & ~eoc_q;

    always_comb begin
        eoc_d  = eoc_q;
        exit_d = exit_q;
        if (eoc_set) begin
            eoc_d  = 1'b1;
            exit_d = {1'b0, wdata_i[31:1]};
        end
    end

    // Read data is captured from the state seen in the request cycle.
    always_comb begin
        rdata_d = '0;
        if (req_i && !we_i) begin
            case (addr_i[3:2])
                2'd1:    rdata_d = {30'd0, tx_busy, eoc_q};
                2'd2:    rdata_d = exit_q;
                default: rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            eoc_q    <= 1'b0;
            exit_q   <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            eoc_q    <= eoc_d;
            exit_q   <= exit_d;
            rvalid_q <= req_i;
            rdata_q  <= rdata_d;
        end
    end

    assign eoc_o       = eoc_q;
    assign exit_code_o = exit_q;
    assign rvalid_o    = rvalid_q;
    assign rdata_o     = rdata_q;

`ifdef PB_EOC_UART_EN

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } tx_state_e;

    localparam int DivW = $clog2(ClkDiv);

    tx_state_e        state_q, state_d;
    logic [DivW-1:0]  div_q, div_d;
    logic [2:0]       bit_q, bit_d;
    logic [2:0]       byte_q, byte_d;
    logic             tx_q, tx_d;
    logic             div_last;
    logic [7:0]       next_byte;

    assign div_last = (div_q == DivW'(ClkDiv - 1));

    // Next-state logic. Every non-idle state holds for ClkDiv cycles.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        case (state_q)
            S_IDLE: begin
                div_d  = '0;
                bit_d  = '0;
                byte_d = '0;
                if (eoc_set) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (div_last) begin
                    div_d   = '0;
                    bit_d   = '0;
                    state_d = S_DATA;
                end else begin
                    div_d = div_q + DivW'(1);
                end
            end
            S_DATA: begin
                if (div_last) begin
                    div_d = '0;
                    if (bit_q == 3'd7) begin
                        bit_d   = '0;
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    div_d = div_q + DivW'(1);
                end
            end
            S_STOP: begin
                if (div_last) begin
                    div_d = '0;
                    if (byte_q == 3'd4) begin
                        byte_d  = '0;
                        state_d = S_IDLE;
                    end else begin
                        byte_d  = byte_q + 3'd1;
                        state_d = S_START;
                    end
                end else begin
                    div_d = div_q + DivW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Frame byte for the upcoming cycle; exit_q is already latched by the
    // time any data bit is sent.
    always_comb begin
        case (byte_d)
            3'd0:    next_byte = SyncByte;
            3'd1:    next_byte = exit_q[7:0];
            3'd2:    next_byte = exit_q[15:8];
            3'd3:    next_byte = exit_q[23:16];
            default: next_byte = exit_q[31:24];
        endcase
    end

    // Line level is derived from the next state and registered, so the
    // output flop changes together with the state and never glitches.
    always_comb begin
        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = next_byte[bit_d];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            tx_q    <= tx_d;
        end
    end

    assign tx_busy   = (state_q != S_IDLE);
    assign uart_tx_o = tx_q;

`else

    // Without the transmitter the frame parameters have no consumer.
    logic unused_cfg;
    assign unused_cfg = ^{SyncByte, (ClkDiv > 1)};

    assign tx_busy   = 1'b0;
    assign uart_tx_o = 1'b1;

`endif

endmodule
